// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use/branch/HI-LO stalls, execute bubbles,
// forwarding selects and HI/LO busy tracking. Defining HAZARD_PERF_COUNTERS_EN adds the stall-cycle counter.

module hazard_unit_checker (
   input logic       clk,
   input logic       reset,
   input logic       hi_lo_start_execute,
   input logic [3:0] cnt
);
   // A mult/div reaching execute while the HI/LO unit still counts means decode failed to stall it.
   start_while_busy: assert property (@(posedge clk) disable iff (reset)
      !(hi_lo_start_execute && (cnt != 4'd0)))
      else $error("hazard_unit: hi_lo start while busy ignored");
endmodule

module hazard_unit #(
   parameter int unsigned MULT_LATENCY = 4,
   parameter int unsigned DIV_LATENCY  = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rs_decode,
   input  logic [4:0]  Rt_decode,
   input  logic [4:0]  Rs_execute,
   input  logic [4:0]  Rt_execute,
   input  logic [4:0]  write_register_execute,
   input  logic [4:0]  write_register_memory,
   input  logic [4:0]  write_register_writeback,
   input  logic        register_write_execute,
   input  logic        register_write_memory,
   input  logic        register_write_writeback,
   input  logic        memory_to_register_execute,
   input  logic        memory_to_register_memory,
   input  logic        branch_decode,
   input  logic        hi_lo_start_execute,
   input  logic        is_div_execute,
   input  logic        hi_lo_access_decode,
   output logic        stall_fetch,
   output logic        stall_decode,
   output logic        flush_execute,
   output logic [1:0]  forward_A_execute,
   output logic [1:0]  forward_B_execute,
   output logic        forward_A_decode,
   output logic        forward_B_decode,
   output logic        hi_lo_busy,
   output logic [31:0] stall_cycle_count
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_LATENCY);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LATENCY);

   logic [3:0] cnt_r;
   logic       busy_s;
   logic       load_stall_s;
   logic       branch_stall_s;
   logic       hi_lo_stall_s;
   logic       stall_s;

   // $0 is hardwired to zero, so it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
      return (dest != 5'd0) && (dest == src);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       wr_mem, input logic [4:0] dst_mem,
                                          input logic       wr_wb,  input logic [4:0] dst_wb);
      logic [1:0] sel;
      if (wr_mem && reg_match(dst_mem, src)) begin
         sel = 2'b10;
      end else if (wr_wb && reg_match(dst_wb, src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // HI/LO busy countdown, loaded when a mult/div leaves execute.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= 4'd0;
      end else if (hi_lo_start_execute && (cnt_r == 4'd0)) begin
         cnt_r <= is_div_execute ? DIV_CNT : MULT_CNT;
      end else if (cnt_r != 4'd0) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Stall and forwarding decisions; everything is forced low while reset is held.
   always_comb begin
      busy_s            = 1'b0;
      load_stall_s      = 1'b0;
      branch_stall_s    = 1'b0;
      hi_lo_stall_s     = 1'b0;
      stall_s           = 1'b0;
      forward_A_execute = 2'b00;
      forward_B_execute = 2'b00;
      forward_A_decode  = 1'b0;
      forward_B_decode  = 1'b0;
      if (reset) begin
         busy_s = 1'b0;
      end else begin
         busy_s         = (cnt_r != 4'd0);
         load_stall_s   = memory_to_register_execute &
                          (reg_match(write_register_execute, Rs_decode) |
                           reg_match(write_register_execute, Rt_decode));
         branch_stall_s = branch_decode &
                          ((register_write_execute &
                            (reg_match(write_register_execute, Rs_decode) |
                             reg_match(write_register_execute, Rt_decode))) |
                           (memory_to_register_memory &
                            (reg_match(write_register_memory, Rs_decode) |
                             reg_match(write_register_memory, Rt_decode))));
         hi_lo_stall_s  = hi_lo_access_decode & (busy_s | hi_lo_start_execute);
         stall_s        = load_stall_s | branch_stall_s | hi_lo_stall_s;
         forward_A_execute = fwd_sel(Rs_execute, register_write_memory, write_register_memory,
                                     register_write_writeback, write_register_writeback);
         forward_B_execute = fwd_sel(Rt_execute, register_write_memory, write_register_memory,
                                     register_write_writeback, write_register_writeback);
         forward_A_decode  = register_write_memory & reg_match(write_register_memory, Rs_decode);
         forward_B_decode  = register_write_memory & reg_match(write_register_memory, Rt_decode);
      end
   end

   assign stall_fetch   = stall_s;
   assign stall_decode  = stall_s;
   assign flush_execute = stall_s;
   assign hi_lo_busy    = busy_s;

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] perf_cnt_r;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cnt_r <= 32'd0;
      end else if (stall_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
         perf_cnt_r <= perf_cnt_r + 32'd1;
      end else begin
         perf_cnt_r <= perf_cnt_r;
      end
   end

   assign stall_cycle_count = reset ? 32'd0 : perf_cnt_r;
`else
   assign stall_cycle_count = 32'd0;
`endif

   hazard_unit_checker u_checker (
      .clk                 (clk),
      .reset               (reset),
      .hi_lo_start_execute (hi_lo_start_execute),
      .cnt                 (cnt_r)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline scenarios plus random traffic
// compared against a cycle-indexed behavioural model.

module tb_hazard_unit;
   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_d, rt_d, rs_e, rt_e, wr_ex, wr_mem, wr_wb;
   logic        rw_ex, rw_mem, rw_wb, m2r_ex, m2r_mem, br_d, start_e, div_e, acc_d;
   logic        stall_fetch, stall_decode, flush_execute;
   logic [1:0]  fa_e, fb_e;
   logic        fa_d, fb_d, hi_lo_busy;
   logic [31:0] stall_cycle_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc        = 0;
   int busy_until = -1;
   int stall_total = 0;

   always #5 clk = ~clk;

   hazard_unit #(.MULT_LATENCY(MULT_LAT), .DIV_LATENCY(DIV_LAT)) dut (
      .clk(clk), .reset(reset),
      .Rs_decode(rs_d), .Rt_decode(rt_d), .Rs_execute(rs_e), .Rt_execute(rt_e),
      .write_register_execute(wr_ex), .write_register_memory(wr_mem),
      .write_register_writeback(wr_wb),
      .register_write_execute(rw_ex), .register_write_memory(rw_mem),
      .register_write_writeback(rw_wb),
      .memory_to_register_execute(m2r_ex), .memory_to_register_memory(m2r_mem),
      .branch_decode(br_d), .hi_lo_start_execute(start_e), .is_div_execute(div_e),
      .hi_lo_access_decode(acc_d),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode), .flush_execute(flush_execute),
      .forward_A_execute(fa_e), .forward_B_execute(fb_e),
      .forward_A_decode(fa_d), .forward_B_decode(fb_d),
      .hi_lo_busy(hi_lo_busy), .stall_cycle_count(stall_cycle_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit dep(input int dest, input int src);
      return (dest != 0) && (dest == src);
   endfunction

   function automatic int fwd(input int src);
      if (rw_mem && dep(wr_mem, src)) return 2;
      if (rw_wb && dep(wr_wb, src)) return 1;
      return 0;
   endfunction

   function automatic bit model_busy();
      return cyc <= busy_until;
   endfunction

   task automatic clear_inputs();
      {rs_d, rt_d, rs_e, rt_e, wr_ex, wr_mem, wr_wb} = '0;
      {rw_ex, rw_mem, rw_wb, m2r_ex, m2r_mem, br_d, start_e, div_e, acc_d} = '0;
   endtask

   // Inputs are already driven at the negedge; check outputs, then advance the model over the posedge.
   task automatic tick();
      bit busy, ld, br, hl, st;
      int fa, fb, perf;
      #1;
      busy = !reset && model_busy();
      ld = m2r_ex && (dep(wr_ex, rs_d) || dep(wr_ex, rt_d));
      br = br_d && ((rw_ex && (dep(wr_ex, rs_d) || dep(wr_ex, rt_d))) ||
                    (m2r_mem && (dep(wr_mem, rs_d) || dep(wr_mem, rt_d))));
      hl = acc_d && (busy || start_e);
      st = !reset && (ld || br || hl);
      fa = reset ? 0 : fwd(rs_e);
      fb = reset ? 0 : fwd(rt_e);
`ifdef HAZARD_PERF_COUNTERS_EN
      perf = reset ? 0 : stall_total;
`else
      perf = 0;
`endif
      check_eq("stall_fetch",   32'(stall_fetch),   32'(st));
      check_eq("stall_decode",  32'(stall_decode),  32'(st));
      check_eq("flush_execute", 32'(flush_execute), 32'(st));
      check_eq("fwd_A_execute", 32'(fa_e), 32'(fa));
      check_eq("fwd_B_execute", 32'(fb_e), 32'(fb));
      check_eq("fwd_A_decode",  32'(fa_d), 32'(!reset && rw_mem && dep(wr_mem, rs_d)));
      check_eq("fwd_B_decode",  32'(fb_d), 32'(!reset && rw_mem && dep(wr_mem, rt_d)));
      check_eq("hi_lo_busy",    32'(hi_lo_busy), 32'(busy));
      check_eq("stall_count",   stall_cycle_count, 32'(perf));
      @(posedge clk);
      if (reset) begin
         busy_until  = cyc;
         stall_total = 0;
      end else begin
         if (start_e && !model_busy()) busy_until = cyc + (div_e ? DIV_LAT : MULT_LAT);
         if (st) stall_total++;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      // Reset state with hazards present on the inputs: outputs must still read zero.
      rw_mem = 1'b1; wr_mem = 5'd3; rs_e = 5'd3; m2r_ex = 1'b1; wr_ex = 5'd1; rs_d = 5'd1;
      tick();
      check_eq("reset_stall", 32'(stall_fetch), 32'd0);
      do_reset();

      // Load-use stall, then no stall once the load target no longer matches.
      m2r_ex = 1'b1; rw_ex = 1'b1; wr_ex = 5'd1; rs_d = 5'd1;
      #1 check_eq("s1_load_stall", 32'(flush_execute), 32'd1);
      tick();
      wr_ex = 5'd0;
      #1 check_eq("s1_zero_dest", 32'(stall_fetch), 32'd0);
      tick();
      clear_inputs();

      // Execute forwarding priority.
      rw_mem = 1'b1; wr_mem = 5'd3; rw_wb = 1'b1; wr_wb = 5'd3; rs_e = 5'd3;
      #1 check_eq("s2_fwd_mem", 32'(fa_e), 32'd2);
      tick();
      rw_mem = 1'b0;
      #1 check_eq("s2_fwd_wb", 32'(fa_e), 32'd1);
      tick();
      clear_inputs();

      // Branch depends on ALU result in execute, then forwards from memory.
      br_d = 1'b1; rt_d = 5'd5; rw_ex = 1'b1; wr_ex = 5'd5;
      #1 check_eq("s3_br_stall", 32'(stall_decode), 32'd1);
      tick();
      rw_ex = 1'b0; wr_ex = 5'd0; rw_mem = 1'b1; wr_mem = 5'd5;
      #1 check_eq("s3_br_release", 32'(stall_decode), 32'd0);
      check_eq("s3_fwd_B_decode", 32'(fb_d), 32'd1);
      tick();
      clear_inputs();

      // Mult followed by mfhi: five stalled cycles, released on the sixth.
      do_reset();
      start_e = 1'b1; acc_d = 1'b1;
      tick();
      start_e = 1'b0;
      for (int i = 0; i < MULT_LAT; i++) begin
         #1 check_eq("s4_busy_stall", 32'(stall_fetch), 32'd1);
         tick();
      end
      #1 check_eq("s4_released", 32'(stall_fetch), 32'd0);
      check_eq("s4_not_busy", 32'(hi_lo_busy), 32'd0);
`ifdef HAZARD_PERF_COUNTERS_EN
      check_eq("s6_perf_count", stall_cycle_count, 32'd5);
`else
      check_eq("s6_perf_count", stall_cycle_count, 32'd0);
`endif
      tick();
      clear_inputs();

      // Divide abandoned by reset at busy cycle 6.
      do_reset();
      start_e = 1'b1; div_e = 1'b1;
      tick();
      start_e = 1'b0; div_e = 1'b0;
      for (int i = 1; i < 6; i++) tick();
      #1 check_eq("s5_busy_before_reset", 32'(hi_lo_busy), 32'd1);
      reset = 1'b1; acc_d = 1'b1;
      tick();
      reset = 1'b0;
      #1 check_eq("s5_busy_cleared", 32'(hi_lo_busy), 32'd0);
      check_eq("s5_no_stall", 32'(stall_fetch), 32'd0);
      tick();
      clear_inputs();

      // Random traffic; a mult/div only starts when the model says the unit is idle.
      for (int n = 0; n < 3000; n++) begin
         reset   = ($urandom_range(0, 99) == 0);
         rs_d    = 5'($urandom_range(0, 3));
         rt_d    = 5'($urandom_range(0, 3));
         rs_e    = 5'($urandom_range(0, 3));
         rt_e    = 5'($urandom_range(0, 3));
         wr_ex   = 5'($urandom_range(0, 3));
         wr_mem  = 5'($urandom_range(0, 3));
         wr_wb   = 5'($urandom_range(0, 3));
         rw_ex   = 1'($urandom);
         rw_mem  = 1'($urandom);
         rw_wb   = 1'($urandom);
         m2r_ex  = ($urandom_range(0, 3) == 0);
         m2r_mem = ($urandom_range(0, 3) == 0);
         br_d    = ($urandom_range(0, 3) == 0);
         acc_d   = 1'($urandom);
         div_e   = 1'($urandom);
         start_e = !model_busy() && ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
